// File: rtl/pll_seq_pkg.sv
// Shared types and width helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        WAIT   = 3'd1,
        STABLE = 3'd2,
        REL    = 3'd3,
        RUN    = 3'd4,
        FAULT  = 3'd5
    } pll_seq_state_t;

    // Width of the shared cycle counter: enough bits for the largest
    // duration parameter plus one, so the counter can never wrap.
    function automatic int cnt_w(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        m = (d > m) ? d : m;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL/MMCM power-up and recovery sequencer: PLL reset pulse, lock
// qualification (timeout + stability window), staggered domain reset
// release, bounded retries with a sticky fault.
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN adds a saturating lock-loss
// counter output loss_cnt[7:0].
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int N_DOMAINS     = 4,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGGER       = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           locked,
    input  logic                           relock_req,
    output logic                           pll_rst,
    output logic [N_DOMAINS-1:0]           dom_rst,
    output logic                           ready,
    output logic                           fault,
`ifdef PLL_SEQ_LOSS_CNT_EN
    output logic [7:0]                     loss_cnt,
`endif
    output logic [$clog2(MAX_RETRY+2)-1:0] retry_cnt
);

    localparam int CNT_W = cnt_w(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGGER);
    localparam int RW    = $clog2(MAX_RETRY + 2);
    localparam int IDX_W = $clog2(N_DOMAINS + 1);

    logic                 lock_s;
    pll_seq_state_t       state_r, state_nx;
    logic [CNT_W-1:0]     cnt_r, cnt_nx;
    logic [RW-1:0]        retry_r, retry_nx;
    logic [IDX_W-1:0]     idx_r, idx_nx;
    pll_seq_state_t       fail_state_s;
    logic [RW-1:0]        fail_retry_s;
    logic                 pll_rst_r, pll_rst_nx;
    logic [N_DOMAINS-1:0] dom_rst_r, dom_rst_nx;
    logic                 ready_r, ready_nx;
    logic                 fault_r, fault_nx;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    // Outcome of a failed attempt: last tolerated failure goes to FAULT.
    assign fail_state_s = (retry_r == RW'(MAX_RETRY)) ? FAULT : HOLD;
    assign fail_retry_s = (retry_r == RW'(MAX_RETRY)) ? retry_r : (retry_r + RW'(1));

    // Next-state, counter, retry and release-index logic.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        retry_nx = retry_r;
        idx_nx   = idx_r;
        if (relock_req) begin
            state_nx = HOLD;
            cnt_nx   = {CNT_W{1'b0}};
            retry_nx = {RW{1'b0}};
            idx_nx   = {IDX_W{1'b0}};
        end else begin
            case (state_r)
                HOLD: begin
                    if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
                        state_nx = WAIT;
                        cnt_nx   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nx = cnt_r + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (lock_s) begin
                        state_nx = STABLE;
                        cnt_nx   = {CNT_W{1'b0}};
                    end else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_nx = fail_state_s;
                        retry_nx = fail_retry_s;
                        cnt_nx   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nx = cnt_r + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_nx = fail_state_s;
                        retry_nx = fail_retry_s;
                        cnt_nx   = {CNT_W{1'b0}};
                    end else if (cnt_r == CNT_W'(STABLE_CYCLES - 1)) begin
                        // A single domain is fully released on entry.
                        state_nx = (N_DOMAINS == 1) ? RUN : REL;
                        retry_nx = {RW{1'b0}};
                        cnt_nx   = {CNT_W{1'b0}};
                        idx_nx   = {IDX_W{1'b0}};
                    end else begin
                        cnt_nx = cnt_r + CNT_W'(1);
                    end
                end
                REL: begin
                    if (!lock_s) begin
                        state_nx = HOLD;
                        cnt_nx   = {CNT_W{1'b0}};
                        idx_nx   = {IDX_W{1'b0}};
                    end else if (cnt_r == CNT_W'(STAGGER - 1)) begin
                        // cnt restarts per release; idx is the newest released domain.
                        cnt_nx = {CNT_W{1'b0}};
                        idx_nx = idx_r + IDX_W'(1);
                        if (int'(idx_r) + 2 == N_DOMAINS) begin
                            state_nx = RUN;
                        end else begin
                            state_nx = REL;
                        end
                    end else begin
                        cnt_nx = cnt_r + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_nx = HOLD;
                        cnt_nx   = {CNT_W{1'b0}};
                    end else begin
                        state_nx = RUN;
                    end
                end
                FAULT: begin
                    state_nx = FAULT;
                end
                default: begin
                    state_nx = HOLD;
                    cnt_nx   = {CNT_W{1'b0}};
                    retry_nx = {RW{1'b0}};
                    idx_nx   = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Output values derived from the state about to be entered.
    always_comb begin
        pll_rst_nx = (state_nx == HOLD) || (state_nx == FAULT);
        ready_nx   = (state_nx == RUN);
        fault_nx   = (state_nx == FAULT);
        dom_rst_nx = {N_DOMAINS{1'b1}};
        case (state_nx)
            REL: begin
                for (int i = 0; i < N_DOMAINS; i++) begin
                    dom_rst_nx[i] = (i > int'(idx_nx));
                end
            end
            RUN: begin
                dom_rst_nx = {N_DOMAINS{1'b0}};
            end
            default: begin
                dom_rst_nx = {N_DOMAINS{1'b1}};
            end
        endcase
    end

    // FSM state, shared counter, retry count and release index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= HOLD;
            cnt_r   <= {CNT_W{1'b0}};
            retry_r <= {RW{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            retry_r <= retry_nx;
            idx_r   <= idx_nx;
        end
    end

    // Registered outputs, updated in the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pll_rst_r <= 1'b1;
            dom_rst_r <= {N_DOMAINS{1'b1}};
            ready_r   <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            pll_rst_r <= pll_rst_nx;
            dom_rst_r <= dom_rst_nx;
            ready_r   <= ready_nx;
            fault_r   <= fault_nx;
        end
    end

    assign pll_rst   = pll_rst_r;
    assign dom_rst   = dom_rst_r;
    assign ready     = ready_r;
    assign fault     = fault_r;
    assign retry_cnt = retry_r;

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_r;
    logic       loss_ev_s;

    // Lock loss in REL/RUN, unless a relock request takes priority.
    assign loss_ev_s = !relock_req && !lock_s && ((state_r == REL) || (state_r == RUN));

    // Saturating lock-loss event counter, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt_r <= 8'd0;
        end else if (loss_ev_s && (loss_cnt_r != 8'hFF)) begin
            loss_cnt_r <= loss_cnt_r + 8'd1;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign loss_cnt = loss_cnt_r;
`endif

endmodule
